grostl_perm_ctrl: RTL and testbench

GROSTL_PERM_CTRL -- requirements
Module: grostl_perm_ctrl

---
 rtl/grostl_perm_ctrl.sv | 136 +++++++++++++
 tb/tb_grostl_perm_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grostl_perm_ctrl.sv
// ----------------------------------------------------------------------------
// grostl_perm_ctrl
//   Sequencer for one Groestl compression f(h,m) = P(h^m) ^ Q(m) ^ h on a
//   datapath where P and Q share a single round engine and alternate
//   cycle by cycle (P first, then Q, for each round index).
//
//   Parameter
//     NUM_ROUNDS : rounds per permutation (10 or 14)
//
//   Ports
//     clk       in   clock, every state update on the rising edge
//     rst_n     in   synchronous active-low reset
//     start     in   request one compression (only taken in IDLE, or in
//                    DONE together with out_ready)
//     busy      out  controller is not idle
//     load      out  capture h^m into the P state and m into the Q state
//     round_en  out  write back the shared round result this cycle
//     perm_sel  out  permutation in the shared datapath (0 = P, 1 = Q)
//     round     out  round index for round-constant generation
//     final_en  out  latch P ^ Q ^ h into the chaining register
//     out_valid out  chaining result available
//     out_ready in   consumer accepts the result (only looked at in DONE)
//
//   Every output is decoded from registered state only; start and
//   out_ready never reach an output combinationally.
// ----------------------------------------------------------------------------
module grostl_perm_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       load,
  output logic       round_en,
  output logic       perm_sel,
  output logic [3:0] round,
  output logic       final_en,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Index of the last round; the Q half of this round ends the ROUND phase.
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_t     state_r;
  state_t     state_s;
  logic [3:0] round_r;
  logic [3:0] round_s;
  logic       perm_r;
  logic       perm_s;

  // State, round counter and P/Q selector registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      round_r <= 4'd0;
      perm_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      round_r <= round_s;
      perm_r  <= perm_s;
    end
  end

  // Next-state logic; round and perm_sel are forced to 0 outside ROUND.
  always_comb begin
    state_s = state_r;
    round_s = 4'd0;
    perm_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        state_s = ROUND;
      end
      ROUND: begin
        if (perm_r && (round_r == LAST_ROUND)) begin
          // Q half of the last round: counters wrap to 0 on exit.
          state_s = FINAL;
        end else if (perm_r) begin
          // Q half done: advance the round, next cycle is P again.
          state_s = ROUND;
          round_s = round_r + 4'd1;
          perm_s  = 1'b0;
        end else begin
          // P half done: same round, next cycle is Q.
          state_s = ROUND;
          round_s = round_r;
          perm_s  = 1'b1;
        end
      end
      FINAL: begin
        state_s = DONE;
      end
      DONE: begin
        // A start arriving with the handshake chains straight into LOAD.
        if (out_ready && start) begin
          state_s = LOAD;
        end else if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode purely from the registered state and counters.
  always_comb begin
    busy      = (state_r != IDLE);
    load      = (state_r == LOAD);
    round_en  = (state_r == ROUND);
    final_en  = (state_r == FINAL);
    out_valid = (state_r == DONE);
    perm_sel  = perm_r;
    round     = round_r;
  end

endmodule

// File: tb/tb_grostl_perm_ctrl.sv
// ----------------------------------------------------------------------------
// tb_grostl_perm_ctrl
//   Directed bench for grostl_perm_ctrl. Two instances share the inputs:
//   dut_a with NUM_ROUNDS=10 and dut_b with NUM_ROUNDS=14. Inputs are driven
//   and outputs sampled at the falling edge; "cycle c" is the interval after
//   rising edge c, with start sampled at edge 0.
// ----------------------------------------------------------------------------
module tb_grostl_perm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       out_ready;

  logic       busy_a, load_a, round_en_a, perm_sel_a, final_en_a, out_valid_a;
  logic [3:0] round_a;
  logic       busy_b, load_b, round_en_b, perm_sel_b, final_en_b, out_valid_b;
  logic [3:0] round_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  grostl_perm_ctrl #(.NUM_ROUNDS(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a), .load(load_a),
    .round_en(round_en_a), .perm_sel(perm_sel_a), .round(round_a),
    .final_en(final_en_a), .out_valid(out_valid_a), .out_ready(out_ready)
  );

  grostl_perm_ctrl #(.NUM_ROUNDS(14)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_b), .load(load_b),
    .round_en(round_en_b), .perm_sel(perm_sel_b), .round(round_b),
    .final_en(final_en_b), .out_valid(out_valid_b), .out_ready(out_ready)
  );

  // Output snapshot: {busy, load, round_en, perm_sel, round[3:0], final_en, out_valid}
  logic [9:0] obs_a;
  logic [9:0] obs_b;
  assign obs_a = {busy_a, load_a, round_en_a, perm_sel_a, round_a, final_en_a, out_valid_a};
  assign obs_b = {busy_b, load_b, round_en_b, perm_sel_b, round_b, final_en_b, out_valid_b};

  // Expected snapshot c cycles after a start at edge 0 with out_ready high.
  function automatic logic [9:0] tr(input int c, input int n);
    logic       b, l, r, p, f, v;
    logic [3:0] rd;
    l  = (c == 1);
    r  = (c >= 2) && (c <= 2 * n + 1);
    p  = r ? 1'((c - 2) % 2) : 1'b0;
    rd = r ? 4'((c - 2) / 2) : 4'd0;
    f  = (c == 2 * n + 2);
    v  = (c == 2 * n + 3);
    b  = (c >= 1) && (c <= 2 * n + 3);
    return {b, l, r, p, rd, f, v};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    start     = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_a !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_a: got %b want %b", obs_a, 10'd0);
    end
    n_cmp++;
    if (obs_b !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_b: got %b want %b", obs_b, 10'd0);
    end
    // start held during reset must not be remembered.
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs_a !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_start_discard: got %b want %b", obs_a, 10'd0);
    end
  endtask

  task automatic test_rounds10();
    apply_reset();
    start = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (obs_a !== tr(c, 10)) begin
        n_bad++;
        $display("FAIL rounds10 cycle %0d: got %b want %b", c, obs_a, tr(c, 10));
      end
    end
  endtask

  task automatic test_rounds14();
    int max_rd;
    max_rd = 0;
    apply_reset();
    start = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (int'(round_b) > max_rd) max_rd = int'(round_b);
      n_cmp++;
      if (obs_b !== tr(c, 14)) begin
        n_bad++;
        $display("FAIL rounds14 cycle %0d: got %b want %b", c, obs_b, tr(c, 14));
      end
    end
    n_cmp++;
    if (max_rd !== 13) begin
      n_bad++;
      $display("FAIL rounds14_max_round: got %0d want %0d", max_rd, 13);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] exp;
    apply_reset();
    out_ready = 1'b0;
    start     = 1'b1;
    for (int c = 1; c <= 29; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= 22) exp = tr(c, 10);
      else if (c <= 27) exp = {1'b1, 3'b000, 4'd0, 1'b0, 1'b1};
      else exp = 10'd0;
      n_cmp++;
      if (obs_a !== exp) begin
        n_bad++;
        $display("FAIL backpressure cycle %0d: got %b want %b", c, obs_a, exp);
      end
      if (c == 27) out_ready = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    int nf, nv;
    nf = 0;
    nv = 0;
    apply_reset();
    start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      exp = (c <= 23) ? tr(c, 10) : tr(c - 23, 10);
      nf += int'(final_en_a);
      nv += int'(out_valid_a);
      n_cmp++;
      if (obs_a !== exp) begin
        n_bad++;
        $display("FAIL back_to_back cycle %0d: got %b want %b", c, obs_a, exp);
      end
      if (c == 23) start = 1'b1;
    end
    n_cmp++;
    if (nf !== 2 || nv !== 2) begin
      n_bad++;
      $display("FAIL back_to_back_pulses: got final %0d valid %0d want 2 and 2", nf, nv);
    end
  endtask

  task automatic test_extra_start();
    int nf, nv;
    nf = 0;
    nv = 0;
    apply_reset();
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = (c == 1) || (c == 5) || (c == 12) || (c == 22);
      nf += int'(final_en_a);
      nv += int'(out_valid_a);
      n_cmp++;
      if (obs_a !== tr(c, 10)) begin
        n_bad++;
        $display("FAIL extra_start cycle %0d: got %b want %b", c, obs_a, tr(c, 10));
      end
    end
    start = 1'b0;
    n_cmp++;
    if (nf !== 1 || nv !== 1) begin
      n_bad++;
      $display("FAIL extra_start_pulses: got final %0d valid %0d want 1 and 1", nf, nv);
    end
  endtask

  task automatic test_reset_mid();
    int nf;
    nf = 0;
    apply_reset();
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (obs_a !== tr(c, 10)) begin
        n_bad++;
        $display("FAIL reset_mid_pre cycle %0d: got %b want %b", c, obs_a, tr(c, 10));
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs_a !== 10'd0 || obs_b !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_mid_abort: got %b/%b want %b", obs_a, obs_b, 10'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      nf += int'(final_en_a) + int'(busy_a);
    end
    n_cmp++;
    if (nf !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: got %0d busy/final cycles want %0d", nf, 0);
    end
    start = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (obs_a !== tr(c, 10)) begin
        n_bad++;
        $display("FAIL reset_mid_restart cycle %0d: got %b want %b", c, obs_a, tr(c, 10));
      end
    end
  endtask

  initial begin
    test_reset();
    test_rounds10();
    test_rounds14();
    test_backpressure();
    test_back_to_back();
    test_extra_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
